exe_mem_stage: RTL and testbench

- Execute stage plus EXE/MEM pipeline register, directly downstream of the ID/EXE register.
- Selects operand B, runs a single-cycle ALU or a multi-cycle shift-add multiplier, and registers the result and control bits for the memory stage.
- Raises a stall to freeze PC, IF/ID and ID/EXE while a multiply is in progress.

---
 rtl/exe_mem_stage.sv | 131 +++++++++++++
 tb/tb_exe_mem_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_stage.sv
// Execute stage with EXE/MEM pipeline register.
// Single-cycle ALU plus a multi-cycle shift-add multiplier that stalls upstream stages.
module exe_mem_stage #(
    parameter int unsigned DATA_W = 32,
    parameter logic [3:0]  MUL_OP = 4'b1010
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic              ewmem,
    input  logic [3:0]        ealuc,
    input  logic              ealuimm,
    input  logic [4:0]        emux,
    input  logic [DATA_W-1:0] eqa,
    input  logic [DATA_W-1:0] eqb,
    input  logic [DATA_W-1:0] esignextendimm,
    output logic              mwreg,
    output logic              mm2reg,
    output logic              mwmem,
    output logic [4:0]        mmux,
    output logic [DATA_W-1:0] malu,
    output logic [DATA_W-1:0] mqb,
    output logic              stall
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] product;
    logic [CNT_W-1:0]  count;

    assign opb = ealuimm ? esignextendimm : eqb;

    always_comb begin
        alu_res = '0;
        case (ealuc)
            4'b0000: alu_res = eqa + opb;
            4'b0001: alu_res = eqa - opb;
            4'b0010: alu_res = eqa & opb;
            4'b0011: alu_res = eqa | opb;
            4'b0100: alu_res = eqa ^ opb;
            4'b0101: alu_res = DATA_W'($signed(eqa) < $signed(opb));
            4'b0110: alu_res = opb << eqa[4:0];
            4'b0111: alu_res = opb >> eqa[4:0];
            4'b1000: alu_res = $signed(opb) >>> eqa[4:0];
            4'b1001: alu_res = opb << 16;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (ealuc == MUL_OP) begin
                    stall      = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                stall = 1'b1;
                if (count == CNT_W'(DATA_W - 1)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            count   <= '0;
        end else if (state == IDLE && ealuc == MUL_OP) begin
            mcand   <= eqa;
            mplier  <= opb;
            product <= '0;
            count   <= '0;
        end else if (state == MUL) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

    // Stalled edges push a bubble so no write escapes to MEM/WB.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            mmux   <= '0;
            malu   <= '0;
            mqb    <= '0;
        end else if (stall) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            mmux   <= '0;
            malu   <= '0;
            mqb    <= '0;
        end else begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            mmux   <= emux;
            malu   <= (state == DONE) ? product : alu_res;
            mqb    <= eqb;
        end
    end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage: driver pushes one expected entry per cycle,
// monitor checks stall mid-cycle and the EXE/MEM outputs after the closing edge.
module tb_exe_mem_stage;

    localparam logic [3:0] MULC = 4'b1010;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ewreg, em2reg, ewmem, ealuimm;
    logic [3:0]  ealuc;
    logic [4:0]  emux;
    logic [31:0] eqa, eqb, esignextendimm;
    logic        mwreg, mm2reg, mwmem, stall;
    logic [4:0]  mmux;
    logic [31:0] malu, mqb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  mux;
        logic [31:0] alu;
        logic [31:0] qb;
    } exp_t;

    exp_t sb[$];

    exe_mem_stage #(.DATA_W(32), .MUL_OP(MULC)) dut (
        .clk(clk), .resetn(resetn),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ealuc(ealuc), .ealuimm(ealuimm), .emux(emux),
        .eqa(eqa), .eqb(eqb), .esignextendimm(esignextendimm),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .mmux(mmux), .malu(malu), .mqb(mqb), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        int          sh;
        sh = int'(a % 32);
        if (op == MULC) begin
            p = {32'b0, a} * {32'b0, b};
            return p[31:0];
        end
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return b * (32'd1 << sh);
            4'd7: return b / (32'd1 << sh);
            4'd8: return 32'($signed(b) >>> sh);
            4'd9: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    // Issue one instruction; a multiply occupies 34 cycles (33 stalled + DONE).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic useimm, input logic wr,
                         input logic m2r, input logic wm, input logic [4:0] rd);
        exp_t        e;
        logic [31:0] bsel;
        int          n;
        bsel = useimm ? imm : b;
        n = (op == MULC) ? 34 : 1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            ealuc = op; eqa = a; eqb = b; esignextendimm = imm; ealuimm = useimm;
            ewreg = wr; em2reg = m2r; ewmem = wm; emux = rd;
            if (c < n - 1) begin
                e = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0};
            end else begin
                e = '{1'b0, wr, m2r, wm, rd, ref_result(op, a, bsel), b};
            end
            sb.push_back(e);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mwreg"}, {31'd0, mwreg}, 32'd0);
        check({tag, "_mm2reg"}, {31'd0, mm2reg}, 32'd0);
        check({tag, "_mwmem"}, {31'd0, mwmem}, 32'd0);
        check({tag, "_mmux"}, {27'd0, mmux}, 32'd0);
        check({tag, "_malu"}, malu, 32'd0);
        check({tag, "_mqb"}, mqb, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("stall", {31'd0, stall}, {31'd0, e.stall});
                @(posedge clk);
                #1;
                check("mwreg", {31'd0, mwreg}, {31'd0, e.wreg});
                check("mm2reg", {31'd0, mm2reg}, {31'd0, e.m2reg});
                check("mwmem", {31'd0, mwmem}, {31'd0, e.wmem});
                check("mmux", {27'd0, mmux}, {27'd0, e.mux});
                check("malu", malu, e.alu);
                check("mqb", mqb, e.qb);
            end
        end
    end

    initial begin : driver
        logic [3:0]  op;
        logic [31:0] ra, rb;
        int          wait_cycles;

        resetn = 1'b0;
        ewreg = 0; em2reg = 0; ewmem = 0; ealuimm = 0;
        ealuc = 4'd0; emux = 5'd0; eqa = 0; eqb = 0; esignextendimm = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        check("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed cases
        issue(4'd0, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9);
        issue(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
        issue(4'd8, 32'd4, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);
        issue(4'd7, 32'd4, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5);
        issue(MULC, 32'd7, 32'hFFFF_FFFD, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6);
        issue(MULC, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7);
        issue(MULC, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8);
        issue(4'd9, 32'd0, 32'h0000_1234, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1);

        // Asynchronous reset with a live result in EXE/MEM
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        @(negedge clk);
        resetn = 1'b1;

        // Reset at cycle 10 of MUL: 1 IDLE cycle + 10 MUL cycles, all stalled bubbles
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            ealuc = MULC; eqa = 32'd9; eqb = 32'd11; ealuimm = 1'b0;
            ewreg = 1'b1; em2reg = 1'b0; ewmem = 1'b0; emux = 5'd2;
            sb.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0});
        end
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_zero_outputs("mid_mul_rst");
        check("mid_mul_rst_stall_mulop", {31'd0, stall}, 32'd1);
        ealuc = 4'd0;
        #1;
        check("mid_mul_rst_stall_idle", {31'd0, stall}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        issue(4'd0, 32'd100, 32'd23, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12);

        // Randomized mix, multiplies kept rare to bound run time
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == MULC && ($urandom % 3 != 0)) op = 4'd0;
            ra = $urandom;
            rb = $urandom;
            if ($urandom % 4 == 0) ra = 32'($urandom_range(0, 40));
            issue(op, ra, rb, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 5'($urandom));
        end

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
